booth_r4_multiplier: RTL and testbench

Iterative radix-4 Booth multiplier that is parametrised in operand width and selects the signedness of each operation at run time. It returns the exact 2·DATA_WIDTH product of signed×signed, signed×unsigned or unsigned×unsigned operands. It sits in the integer multiplier library and keeps the accept / busy / valid handshake of the existing iterative multipliers. It adds per-operation mode select, back-to-back issue and a defined latency formula for any even width.

---
 rtl/booth_mul_pkg.sv | 32 +++
 rtl/booth_r4_multiplier_if.sv | 22 ++
 rtl/booth_r4_recoder.sv | 14 +
 rtl/booth_r4_multiplier.sv | 119 +++++++++++
 tb/tb_booth_r4_multiplier.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package booth_mul_pkg;

  // Operation signedness; encoding 2'b11 is decoded as UU.
  typedef enum logic [1:0] {
    SS = 2'b00,
    SU = 2'b01,
    UU = 2'b10
  } mul_mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b10
  } state_t;

  typedef logic signed [2:0] booth_digit_t;

  // Number of radix-4 digits needed to cover a (width+2)-bit extended multiplier.
  function automatic int unsigned calc_iters(input int unsigned width);
    return width / 2 + 1;
  endfunction

  function automatic logic a_is_signed(input logic [1:0] mode);
    return (mode == SS) || (mode == SU);
  endfunction

  function automatic logic b_is_signed(input logic [1:0] mode);
    return mode == SS;
  endfunction

endpackage

// File: rtl/booth_r4_multiplier_if.sv
// Request/response bundle of the Booth multiplier.
interface booth_r4_multiplier_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid_entry_i;
  logic [1:0]              mode_i;
  logic [DATA_WIDTH-1:0]   operand_A_i;
  logic [DATA_WIDTH-1:0]   operand_B_i;
  logic [2*DATA_WIDTH-1:0] result_o;
  logic                    data_valid_o;
  logic                    busy_o;

  modport master (
    output valid_entry_i, mode_i, operand_A_i, operand_B_i,
    input  result_o, data_valid_o, busy_o
  );

  modport slave (
    input  valid_entry_i, mode_i, operand_A_i, operand_B_i,
    output result_o, data_valid_o, busy_o
  );
endinterface

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth digit recoder: 3 overlapping multiplier bits to select flags.
module booth_r4_recoder (
  input  logic [2:0] bits,
  output logic       negate,
  output logic       one,
  output logic       two
);
  // 111 and 000 both map to digit 0, so negate is kept low for them.
  always_comb begin
    negate = bits[2] & ~(bits[1] & bits[0]);
    one    = bits[1] ^ bits[0];
    two    = (bits[2] & ~bits[1] & ~bits[0]) | (~bits[2] & bits[1] & bits[0]);
  end
endmodule

// File: rtl/booth_r4_multiplier.sv
// Iterative radix-4 Booth multiplier with run-time signedness select.
module booth_r4_multiplier
  import booth_mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                  clk_i,
  input logic                  rst_i,
  input logic                  clk_en_i,
  booth_r4_multiplier_if.slave bus
);
  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned ExtW  = W + 2;
  localparam int unsigned ProdW = 2 * ExtW + 1;
  localparam int unsigned Iters = calc_iters(W);
  localparam int unsigned CntW  = $clog2(Iters);

  if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 4) begin : g_width_check
    $error("booth_r4_multiplier: DATA_WIDTH must be even and >= 4");
  end

  state_t            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [ProdW-1:0]  prod_q;
  logic [ExtW-1:0]   mcand_q;
  logic [2*W-1:0]    result_q;
  logic              valid_q;
  logic              busy_q;

  logic              accept;
  logic [ExtW-1:0]   a_ext;
  logic [ExtW-1:0]   b_ext;
  logic              rec_neg;
  logic              rec_one;
  logic              rec_two;
  logic [ExtW-1:0]   acc;
  logic [ExtW-1:0]   pp;
  logic [ExtW-1:0]   sum;
  logic [ProdW-1:0]  prod_step;
  logic              unused_step;

  assign accept = bus.valid_entry_i && (state_q != COMPUTE);

  // Extend operands by two bits so the unsigned case also reads as non-negative.
  always_comb begin
    a_ext = {2'b00, bus.operand_A_i};
    b_ext = {2'b00, bus.operand_B_i};
    if (a_is_signed(bus.mode_i)) a_ext = {{2{bus.operand_A_i[W-1]}}, bus.operand_A_i};
    if (b_is_signed(bus.mode_i)) b_ext = {{2{bus.operand_B_i[W-1]}}, bus.operand_B_i};
  end

  booth_r4_recoder u_recoder (
    .bits   (prod_q[2:0]),
    .negate (rec_neg),
    .one    (rec_one),
    .two    (rec_two)
  );

  // One Booth step: add d*A into the upper accumulator, then shift right by 2.
  always_comb begin
    acc = prod_q[ProdW-1 -: ExtW];
    pp  = '0;
    if (rec_one)      pp = mcand_q;
    else if (rec_two) pp = {mcand_q[ExtW-2:0], 1'b0};
    sum       = rec_neg ? (acc - pp) : (acc + pp);
    prod_step = {{2{sum[ExtW-1]}}, sum, prod_q[ExtW:2]};
  end

  // Sign-extension bits and the guard bit never reach the result.
  assign unused_step = ^{prod_step[ProdW-1:2*W+1], prod_step[0]};

  // Control FSM with counter, product register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (clk_en_i) begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q <= COMPUTE;
            busy_q  <= 1'b1;
            mcand_q <= a_ext;
            prod_q  <= {{ExtW{1'b0}}, b_ext, 1'b0};
            cnt_q   <= CntW'(Iters - 1);
          end else begin
            state_q <= IDLE;
          end
        end
        COMPUTE: begin
          prod_q <= prod_step;
          if (cnt_q == '0) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            result_q <= prod_step[2*W:1];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_o     = result_q;
  assign bus.data_valid_o = valid_q;
  assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Scoreboard bench for booth_r4_multiplier at DATA_WIDTH = 32.
module tb_booth_r4_multiplier;
  localparam int W = 32;
  localparam int N = W / 2 + 1;

  typedef struct {
    logic [2*W-1:0] res;
    int             acc_edge;
    int             dis;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  booth_r4_multiplier_if #(.DATA_WIDTH(W)) bus ();

  booth_r4_multiplier #(.DATA_WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clk_en_i (en),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int dis_count = 0;
  int accept_cnt = 0;
  int prev_acc_edge = 0;
  int last_acc_edge = 0;
  logic acc_in_done = 1'b0;
  logic last_en = 1'b0;
  logic dir_valid = 1'b0;
  logic [2*W-1:0] dir_exp = '0;
  exp_t exp_q[$];

  // Golden model: extend each operand per its signedness, then multiply.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] m);
    logic signed [2*W+1:0] ae;
    logic signed [2*W+1:0] be;
    logic signed [2*W+1:0] p;
    ae = (m == 2'b00 || m == 2'b01) ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
    be = (m == 2'b00) ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
    p  = ae * be;
    return p[2*W-1:0];
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
    end
  endtask

  // Observe accepts at the clock edge and queue the expected response.
  always @(posedge clk) begin
    cycle   <= cycle + 1;
    last_en <= en && !rst;
    if (rst) begin
      exp_q.delete();
    end else if (en) begin
      if (bus.valid_entry_i && !bus.busy_o) begin
        exp_q.push_back('{res: dir_valid ? dir_exp
                                         : ref_mul(bus.operand_A_i, bus.operand_B_i, bus.mode_i),
                          acc_edge: cycle + 1, dis: dis_count});
        accept_cnt    <= accept_cnt + 1;
        prev_acc_edge <= last_acc_edge;
        last_acc_edge <= cycle + 1;
        acc_in_done   <= bus.data_valid_o;
      end
    end else begin
      dis_count <= dis_count + 1;
    end
  end

  // Monitor: each fresh data_valid_o pulse consumes one expected entry.
  always @(negedge clk) begin
    if (last_en && bus.data_valid_o) begin
      check64("pending_expect", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check64("result", bus.result_o, e.res);
        check64("latency", 64'(cycle + 1 - e.acc_edge), 64'(N + 1 + dis_count - e.dis));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
    int start;
    int i;
    @(negedge clk);
    bus.valid_entry_i = 1'b1;
    bus.operand_A_i   = a;
    bus.operand_B_i   = b;
    bus.mode_i        = m;
    start = accept_cnt;
    for (i = 0; i < 100 && accept_cnt == start; i++) @(negedge clk);
    if (accept_cnt == start) check64("accept_timeout", 64'(accept_cnt - start), 64'd1);
    bus.valid_entry_i = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200 && (exp_q.size() != 0 || bus.busy_o); i++) @(negedge clk);
    if (exp_q.size() != 0 || bus.busy_o) check64("idle_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic issue_dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                           input logic [2*W-1:0] res);
    dir_exp   = res;
    dir_valid = 1'b1;
    issue(a, b, m);
    dir_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int bc;
    int vc;
    int start;
    rst = 1'b1;
    en  = 1'b1;
    bus.valid_entry_i = 1'b0;
    bus.mode_i        = 2'b00;
    bus.operand_A_i   = '0;
    bus.operand_B_i   = '0;
    repeat (3) @(negedge clk);
    check64("reset_busy", 64'(bus.busy_o), 64'd0);
    check64("reset_valid", 64'(bus.data_valid_o), 64'd0);
    check64("reset_result", bus.result_o, 64'd0);
    rst = 1'b0;

    // -7 * 3 signed, also counting busy cycles.
    dir_exp   = 64'hFFFF_FFFF_FFFF_FFEB;
    dir_valid = 1'b1;
    issue(32'hFFFF_FFF9, 32'd3, 2'b00);
    dir_valid = 1'b0;
    bc = 0;
    for (int i = 0; i < 40 && bus.busy_o; i++) begin
      bc++;
      @(negedge clk);
    end
    check64("busy_cycles", 64'(bc), 64'(N));
    wait_idle();

    issue_dir(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 64'hFFFF_FFFE_0000_0001);
    issue_dir(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 64'hFFFF_FFFE_0000_0001);
    issue_dir(32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 64'h8000_0000_8000_0000);
    issue_dir(32'h8000_0000, 32'h8000_0000, 2'b00, 64'h4000_0000_0000_0000);

    // Back-to-back: 2x3 request is held through the busy window.
    @(negedge clk);
    bus.valid_entry_i = 1'b1;
    bus.operand_A_i = 32'd5;
    bus.operand_B_i = 32'd6;
    bus.mode_i = 2'b10;
    start = accept_cnt;
    for (int i = 0; i < 100 && accept_cnt == start; i++) @(negedge clk);
    bus.operand_A_i = 32'd2;
    bus.operand_B_i = 32'd3;
    start = accept_cnt;
    for (int i = 0; i < 100 && accept_cnt == start; i++) @(negedge clk);
    bus.valid_entry_i = 1'b0;
    check64("b2b_accept_in_done", 64'(acc_in_done), 64'd1);
    check64("b2b_gap", 64'(last_acc_edge - prev_acc_edge), 64'(N + 1));
    wait_idle();

    // Request pulse while busy must be ignored.
    issue(32'd100, 32'd7, 2'b00);
    repeat (3) @(negedge clk);
    bus.valid_entry_i = 1'b1;
    bus.operand_A_i = 32'd9;
    bus.operand_B_i = 32'd9;
    @(negedge clk);
    bus.valid_entry_i = 1'b0;
    start = accept_cnt;
    wait_idle();
    check64("busy_pulse_ignored", 64'(accept_cnt - start), 64'd0);

    // Reset in COMPUTE cycle 8 discards the operation.
    issue(32'd1234, 32'd5678, 2'b00);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check64("midrst_busy", 64'(bus.busy_o), 64'd0);
    check64("midrst_valid", 64'(bus.data_valid_o), 64'd0);
    check64("midrst_result", bus.result_o, 64'd0);
    vc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.data_valid_o) vc++;
    end
    check64("midrst_no_pulse", 64'(vc), 64'd0);

    // Clock enable dropped for 5 cycles mid-operation.
    issue(32'd123456, 32'hFFFE_7E33, 2'b00);
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    wait_idle();

    // Random operands and modes, issued back to back with occasional stalls.
    for (int t = 0; t < 1000; t++) begin
      issue($urandom, $urandom, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        en = 1'b1;
      end
    end
    wait_idle();
    check64("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
